// File: rtl/spi_frame_loader.sv
// SPI-slave pixel feeder for the multi-frame video bank: synchronises the MCU's
// 1-bit-per-pixel stream, strobes pixels with scaled x/y/frame addresses and arbitrates bank write/read mode.
module spi_frame_loader #(
  parameter int unsigned WIDTH      = 640,
  parameter int unsigned HEIGHT     = 480,
  parameter int unsigned X_WIDTH    = WIDTH / 4,
  parameter int unsigned Y_HEIGHT   = HEIGHT / 4,
  parameter int unsigned NUM_FRAMES = 15,
  parameter int unsigned X_ADDRW    = $clog2(X_WIDTH),
  parameter int unsigned Y_ADDRW    = $clog2(Y_HEIGHT),
  parameter int unsigned F_W        = $clog2(NUM_FRAMES)
) (
  input  logic               system_clk,
  input  logic               reset,
  input  logic               load_start,
  input  logic               bank_read_done,
  input  logic               spi_sclk,
  input  logic               spi_mosi,
  input  logic               spi_cs_n,
  output logic               load_req,
  output logic               write_mode,
  output logic               pixel_valid,
  output logic               pixel_data,
  output logic [X_ADDRW-1:0] mem_x_pos,
  output logic [Y_ADDRW-1:0] mem_y_pos,
  output logic [F_W-1:0]     frame_idx,
  output logic               overrun
);

  localparam logic [X_ADDRW-1:0] X_LAST = X_ADDRW'(X_WIDTH - 1);
  localparam logic [Y_ADDRW-1:0] Y_LAST = Y_ADDRW'(Y_HEIGHT - 1);
  localparam logic [F_W-1:0]     F_LAST = F_W'(NUM_FRAMES - 1);

  typedef enum logic [1:0] {IDLE, LOAD, HOLD} state_t;

  state_t     state;
  logic [2:0] sclk_sr;
  logic [2:0] mosi_sr;
  logic [2:0] cs_sr;
  logic       edge_q;
  logic       sclk_rise;
  logic       last_pixel;

  // [0],[1] form the synchroniser, [2] is the history flop; all three lanes share depth
  always_ff @(posedge system_clk) begin
    if (reset) begin
      sclk_sr <= '0;
      mosi_sr <= '0;
      cs_sr   <= '0;
      edge_q  <= 1'b0;
    end else begin
      sclk_sr <= {sclk_sr[1:0], spi_sclk};
      mosi_sr <= {mosi_sr[1:0], spi_mosi};
      cs_sr   <= {cs_sr[1:0], spi_cs_n};
      edge_q  <= sclk_rise;
    end
  end

  // mosi_sr[2] holds the data sampled with the sclk edge that edge_q reports
  always_comb begin
    sclk_rise  = sclk_sr[1] & ~sclk_sr[2] & ~cs_sr[1] & ~cs_sr[2];
    last_pixel = (mem_x_pos == X_LAST) && (mem_y_pos == Y_LAST) && (frame_idx == F_LAST);
  end

  always_ff @(posedge system_clk) begin
    if (reset) begin
      state       <= IDLE;
      load_req    <= 1'b0;
      write_mode  <= 1'b0;
      pixel_valid <= 1'b0;
      pixel_data  <= 1'b0;
      mem_x_pos   <= '0;
      mem_y_pos   <= '0;
      frame_idx   <= '0;
      overrun     <= 1'b0;
    end else begin
      pixel_valid <= 1'b0;

      // addresses stay put during the strobe and advance on the following cycle
      if (pixel_valid) begin
        if (mem_x_pos == X_LAST) begin
          mem_x_pos <= '0;
          if (mem_y_pos == Y_LAST) begin
            mem_y_pos <= '0;
            frame_idx <= (frame_idx == F_LAST) ? '0 : frame_idx + 1'b1;
          end else begin
            mem_y_pos <= mem_y_pos + 1'b1;
          end
        end else begin
          mem_x_pos <= mem_x_pos + 1'b1;
        end
      end

      case (state)
        IDLE: begin
          if (edge_q) overrun <= 1'b1;
          if (load_start) begin
            state      <= LOAD;
            load_req   <= 1'b1;
            write_mode <= 1'b1;
          end
        end
        LOAD: begin
          if (edge_q) begin
            pixel_valid <= 1'b1;
            pixel_data  <= mosi_sr[2];
          end
          if (pixel_valid && last_pixel) begin
            state      <= HOLD;
            load_req   <= 1'b0;
            write_mode <= 1'b0;
          end
        end
        HOLD: begin
          if (edge_q) overrun <= 1'b1;
          if (bank_read_done) begin
            state      <= LOAD;
            load_req   <= 1'b1;
            write_mode <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/spi_frame_loader.md
Name: spi_frame_loader

Overview:
- Upstream write-side feeder for the 15-frame video bank.
- Receives a 1-bit-per-pixel video stream from the external SPI master (the MCU), which the block treats as a slave.
- Synchronises and deserialises the stream into single-cycle pixel strobes, and generates the scaled x/y write address and frame index.
- Drives the bank's write/read mode: holds write mode until all frames are loaded, then releases the bank to read mode until the bank reports read-out complete.

Parameters:
WIDTH, 640, VGA active width
HEIGHT, 480, VGA active height
X_WIDTH, WIDTH/4, scaled frame width (pixels per line written)
Y_HEIGHT, HEIGHT/4, scaled frame height (lines per frame)
NUM_FRAMES, 15, frames per bank fill
X_ADDRW, $clog2(X_WIDTH), width of mem_x_pos
Y_ADDRW, $clog2(Y_HEIGHT), width of mem_y_pos
F_W, $clog2(NUM_FRAMES), width of frame_idx

Ports:
system_clk  in  1  system clock (40 MHz)
reset  in  1  synchronous, active-high
load_start  in  1  one-cycle pulse (debounced button); starts the first fill
bank_read_done  in  1  one-cycle pulse from the bank: all frames displayed
spi_sclk  in  1  async SPI clock, mode 0, max system_clk/8
spi_mosi  in  1  async SPI data; one bit = one pixel, 1 = white
spi_cs_n  in  1  async chip select, active-low
load_req  out  1  high while the block accepts pixels (flow control to the MCU)
write_mode  out  1  write_enable to the bank
pixel_valid  out  1  one-cycle strobe per pixel (bank write clock enable)
pixel_data  out  1  pixel value, valid with pixel_valid
mem_x_pos  out  X_ADDRW  scaled x address of the current pixel
mem_y_pos  out  Y_ADDRW  scaled y address of the current pixel
frame_idx  out  F_W  frame currently being written
overrun  out  1  sticky: an SCLK edge arrived while not accepting pixels

Behaviour:
- Reset values:
  - state=IDLE; load_req=0, write_mode=0, pixel_valid=0, pixel_data=0.
  - mem_x_pos=0, mem_y_pos=0, frame_idx=0, overrun=0.
  - All synchroniser flops cleared.
- Synchronisation:
  - spi_sclk, spi_mosi and spi_cs_n each pass through a 2-flop synchroniser plus one history flop, at equal depth so data stays aligned with clock.
  - Rise edge = sync2 & ~sync3. The edge is qualified only when synchronised cs_n = 0.
- Latency:
  - pixel_valid pulses exactly 3 system_clk cycles after the first rising system_clk edge that samples spi_sclk high.
  - pixel_data is the mosi value captured at that same sample and is held until the next strobe.
- States:
  - IDLE:
    - load_req=0, write_mode=0.
    - load_start -> LOAD.
    - Qualified SCLK edges are dropped and set overrun.
  - LOAD:
    - load_req=1, write_mode=1.
    - Each qualified edge produces a pixel_valid with the current x/y/frame_idx.
  - HOLD:
    - load_req=0, write_mode=0; the bank is in read mode.
    - bank_read_done -> LOAD, with x/y/frame_idx already 0.
    - Qualified edges are dropped and set overrun.
- Address sequencing:
  - mem_x_pos, mem_y_pos and frame_idx are stable during the pixel_valid cycle and update on the following cycle.
  - x increments; at X_WIDTH-1, x wraps to 0 and y increments.
  - At x=X_WIDTH-1 and y=Y_HEIGHT-1, x and y wrap to 0 and frame_idx increments.
  - At the last pixel of frame NUM_FRAMES-1:
    - frame_idx wraps to 0 and the state moves to HOLD.
    - write_mode and load_req fall on the cycle after that strobe, so the bank sees write_mode=1 during its final write.
- cs_n handling:
  - Deasserting cs_n mid-frame only pauses the transfer; counters are kept, so chunked transfers are legal.
  - cs_n toggles never reset counters.
- Simultaneous events:
  - load_start outside IDLE is ignored.
  - bank_read_done outside HOLD is ignored.
  - A qualified edge on the same cycle as the HOLD->LOAD transition is dropped and sets overrun; the MCU must wait for load_req.
- overrun clears only on reset.
- Reset mid-LOAD: everything returns to reset values, and the next fill restarts at frame 0, pixel (0,0).
- Counter widths: all counters are truncated to their port widths; NUM_FRAMES must be at least 2.

Test Plan:
- Reset, load_start, 19200 SPI bits of frame 0 at 1 MHz SCLK:
  - 19200 pixel_valid strobes; first at (0,0), last at (159,119).
  - Then frame_idx=1, x=0, y=0; write_mode stays 1.
- Single-edge latency: SCLK rise with mosi=1 while in LOAD:
  - pixel_valid high exactly 3 cycles after the first high sample, for 1 cycle.
  - pixel_data=1; mem_x_pos=0 during the strobe, 1 on the next cycle.
- Full fill of 15×19200 bits:
  - The last strobe has frame_idx=14, (159,119), write_mode=1.
  - The next cycle: write_mode=0, load_req=0, frame_idx=0.
  - Then pulse bank_read_done: write_mode=1 and load_req=1 on the next cycle.
- Chunked transfer: send 100 bits, raise cs_n for 50 µs with SCLK toggling, lower cs_n, send 100 bits:
  - Exactly 200 strobes; no strobes while cs_n is high.
  - Ends at x=40, y=1.
- Overrun: 5 SCLK edges in IDLE with cs_n low:
  - No pixel_valid; overrun=1.
  - overrun remains 1 after load_start; it clears only on reset.
- Reset asserted at frame 3, pixel (80,60):
  - All outputs return to reset values.
  - After load_start, the first strobe is at frame_idx=0, (0,0).
